// File: rtl/alu_rs.sv
// alu_rs: reservation station and round-robin issue scheduler for the shared ALU.
// Define ALU_RS_DISP_BYPASS_EN to capture a same-cycle CDB broadcast at dispatch.
module alu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,

    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [4:0]       disp_op,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic             disp_qj_busy,
    input  logic             disp_qk_busy,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic [TAG_W-1:0] disp_dest,

    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,

    output logic [31:0]      alu_op1,
    output logic [31:0]      alu_op2,
    output logic [4:0]       alu_opcode,
    input  logic [31:0]      alu_result,

    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_value,
    input  logic             out_ready
);

    localparam logic [IDX_W:0]   FULL    = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] bj_q, bj_d;
    logic [DEPTH-1:0] bk_q, bk_d;
    logic [4:0]       op_q   [DEPTH];
    logic [4:0]       op_d   [DEPTH];
    logic [31:0]      vj_q   [DEPTH];
    logic [31:0]      vj_d   [DEPTH];
    logic [31:0]      vk_q   [DEPTH];
    logic [31:0]      vk_d   [DEPTH];
    logic [TAG_W-1:0] qj_q   [DEPTH];
    logic [TAG_W-1:0] qj_d   [DEPTH];
    logic [TAG_W-1:0] qk_q   [DEPTH];
    logic [TAG_W-1:0] qk_d   [DEPTH];
    logic [TAG_W-1:0] dest_q [DEPTH];
    logic [TAG_W-1:0] dest_d [DEPTH];

    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [31:0]      out_value_q, out_value_d;

    logic [DEPTH-1:0] ready;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             j_hit, k_hit;
    logic [31:0]      ent_vj, ent_vk;
    logic             ent_bj, ent_bk;
    logic             disp_fire;
    logic             issue;

    assign ready = valid_q & ~bj_q & ~bk_q;

    // Round-robin pick: first ready entry at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cand_idx = rr_ptr_q + IDX_W'(i);
            if (!sel_found && ready[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign j_hit = cdb_valid & disp_qj_busy & (disp_qj == cdb_tag);
    assign k_hit = cdb_valid & disp_qk_busy & (disp_qk == cdb_tag);

`ifdef ALU_RS_DISP_BYPASS_EN
    assign ent_vj     = j_hit ? cdb_value : disp_vj;
    assign ent_vk     = k_hit ? cdb_value : disp_vk;
    assign ent_bj     = disp_qj_busy & ~j_hit;
    assign ent_bk     = disp_qk_busy & ~k_hit;
    assign disp_ready = rdy_in & (count_q != FULL);
`else
    assign ent_vj     = disp_vj;
    assign ent_vk     = disp_vk;
    assign ent_bj     = disp_qj_busy;
    assign ent_bk     = disp_qk_busy;
    // Without capture at dispatch, a matching broadcast would be missed.
    assign disp_ready = rdy_in & (count_q != FULL) & ~(j_hit | k_hit);
`endif

    assign disp_fire = disp_valid & disp_ready & ~flush & free_found;
    assign issue     = sel_found & (~out_valid_q | out_ready)
                     & rdy_in & ~flush;

    assign alu_op1    = issue ? vj_q[sel_idx] : '0;
    assign alu_op2    = issue ? vk_q[sel_idx] : '0;
    assign alu_opcode = issue ? op_q[sel_idx] : '0;

    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign out_value = out_value_q;

    always_comb begin
        valid_d     = valid_q;
        bj_d        = bj_q;
        bk_d        = bk_q;
        op_d        = op_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        dest_d      = dest_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_value_d = out_value_q;

        if (flush) begin
            valid_d     = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && cdb_valid) begin
                    if (bj_q[i] && qj_q[i] == cdb_tag) begin
                        vj_d[i] = cdb_value;
                        bj_d[i] = 1'b0;
                    end
                    if (bk_q[i] && qk_q[i] == cdb_tag) begin
                        vk_d[i] = cdb_value;
                        bk_d[i] = 1'b0;
                    end
                end
            end

            if (issue) begin
                valid_d[sel_idx] = 1'b0;
                out_valid_d      = 1'b1;
                out_tag_d        = dest_q[sel_idx];
                out_value_d      = alu_result;
                rr_ptr_d         = sel_idx + IDX_ONE;
            end else if (out_ready && out_valid_q) begin
                out_valid_d = 1'b0;
            end

            // Free slot comes from registered valid, so an issuing entry is not reused.
            if (disp_fire) begin
                valid_d[free_idx] = 1'b1;
                op_d[free_idx]    = disp_op;
                vj_d[free_idx]    = ent_vj;
                vk_d[free_idx]    = ent_vk;
                bj_d[free_idx]    = ent_bj;
                bk_d[free_idx]    = ent_bk;
                qj_d[free_idx]    = disp_qj;
                qk_d[free_idx]    = disp_qk;
                dest_d[free_idx]  = disp_dest;
            end

            if (disp_fire && !issue) begin
                count_d = count_q + CNT_ONE;
            end else if (!disp_fire && issue) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q     <= '0;
            bj_q        <= '0;
            bk_q        <= '0;
            count_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_value_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                dest_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            bj_q        <= bj_d;
            bk_q        <= bk_d;
            op_q        <= op_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            dest_q      <= dest_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_value_q <= out_value_d;
        end
    end

endmodule
